// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the alarm clock setup controller:
// FSM states, edit fields, BCD digit limits and edit_mode encodings.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_SET_TIME,
        ST_SET_ALARM,
        ST_LOAD_TIME,
        ST_LOAD_ALARM,
        ST_STOP
    } state_t;

    typedef enum logic [1:0] {
        FLD_H1,
        FLD_H0,
        FLD_M1,
        FLD_M0
    } field_t;

    localparam logic [1:0] H1_MAX       = 2'd2;
    localparam logic [3:0] H0_MAX       = 4'd9;
    localparam logic [3:0] H0_MAX_AT_20 = 4'd3;
    localparam logic [3:0] M1_MAX       = 4'd5;
    localparam logic [3:0] M0_MAX       = 4'd9;

    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;
    localparam logic [1:0] MODE_BUSY      = 2'd3;

endpackage

// File: rtl/bcd_field_editor.sv
// Next-value logic for the four HH:MM BCD digits when the selected field is
// incremented, applying per-digit wrap limits and the 20..23 hour rule.
module bcd_field_editor
    import clock_ctrl_pkg::*;
(
    input  field_t     field,
    input  logic       inc,
    input  logic [1:0] hou1,
    input  logic [3:0] hou0,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    output logic [1:0] nxt_hou1,
    output logic [3:0] nxt_hou0,
    output logic [3:0] nxt_min1,
    output logic [3:0] nxt_min0
);

    logic [3:0] h0_limit;

    always_comb begin
        nxt_hou1 = hou1;
        nxt_hou0 = hou0;
        nxt_min1 = min1;
        nxt_min0 = min0;
        h0_limit = (hou1 == H1_MAX) ? H0_MAX_AT_20 : H0_MAX;
        if (inc) begin
            case (field)
                FLD_H1: begin
                    nxt_hou1 = (hou1 >= H1_MAX) ? 2'd0 : hou1 + 2'd1;
                    // Entering the 20s with H0 above 3 would give an invalid hour.
                    if (nxt_hou1 == H1_MAX && hou0 > H0_MAX_AT_20)
                        nxt_hou0 = 4'd0;
                end
                FLD_H0: nxt_hou0 = (hou0 >= h0_limit) ? 4'd0 : hou0 + 4'd1;
                FLD_M1: nxt_min1 = (min1 >= M1_MAX) ? 4'd0 : min1 + 4'd1;
                FLD_M0: nxt_min0 = (min0 >= M0_MAX) ? 4'd0 : min0 + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/clock_setup_ctrl.sv
// Button-driven setup controller for the alarm clock: digit editing, held load/stop
// strobes and alarm enable. Optional snooze is built when CLOCK_SNOOZE_EN is defined.
module clock_setup_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int LOAD_HOLD_CYCLES = 12,
    parameter int SNOOZE_SECONDS   = 300
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       alarm,
    input  logic [1:0] cur_hou1,
    input  logic [3:0] cur_hou0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min0,
    output logic [1:0] hou1,
    output logic [3:0] hou0,
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic       loatim,
    output logic       loaala,
    output logic       stoala,
    output logic       alaon,
    output logic       buzzer,
    output logic [1:0] edit_mode,
    output logic [1:0] edit_field
);

    localparam int HOLD_W = $clog2(LOAD_HOLD_CYCLES + 1);

    state_t            state, state_nxt;
    field_t            field, field_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              ld_cur, ld_ala, do_inc, commit, toggle_alaon, snooze_req;
    logic              busy, busy_nxt, editing, muted;

    logic [1:0] e_hou1, l_hou1, a_hou1, n_hou1;
    logic [3:0] e_hou0, l_hou0, a_hou0, n_hou0;
    logic [3:0] e_min1, l_min1, a_min1, n_min1;
    logic [3:0] e_min0, l_min0, a_min0, n_min0;

    bcd_field_editor u_editor (
        .field    (field),
        .inc      (do_inc),
        .hou1     (e_hou1),
        .hou0     (e_hou0),
        .min1     (e_min1),
        .min0     (e_min0),
        .nxt_hou1 (n_hou1),
        .nxt_hou0 (n_hou0),
        .nxt_min1 (n_min1),
        .nxt_min0 (n_min0)
    );

    always_comb begin
        state_nxt    = state;
        field_nxt    = field;
        ld_cur       = 1'b0;
        ld_ala       = 1'b0;
        do_inc       = 1'b0;
        commit       = 1'b0;
        toggle_alaon = 1'b0;
        snooze_req   = 1'b0;
        case (state)
            ST_RUN: begin
                if (btn_mode) begin
                    if (alarm) begin
                        state_nxt = ST_STOP;
                    end else begin
                        state_nxt = ST_SET_TIME;
                        field_nxt = FLD_H1;
                        ld_cur    = 1'b1;
                    end
                end else if (!btn_next && btn_inc) begin
                    // A pending next press outranks inc even though next itself does nothing here.
                    if (alarm) snooze_req   = 1'b1;
                    else       toggle_alaon = 1'b1;
                end
            end
            ST_SET_TIME, ST_SET_ALARM: begin
                if (btn_mode) begin
                    if (state == ST_SET_TIME) begin
                        state_nxt = ST_SET_ALARM;
                        field_nxt = FLD_H1;
                        ld_ala    = 1'b1;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end else if (btn_next) begin
                    if (field == FLD_M0) begin
                        commit    = 1'b1;
                        field_nxt = FLD_H1;
                        state_nxt = (state == ST_SET_TIME) ? ST_LOAD_TIME : ST_LOAD_ALARM;
                    end else begin
                        field_nxt = field_t'(field + 2'd1);
                    end
                end else if (btn_inc) begin
                    do_inc = 1'b1;
                end
            end
            default: begin
                if (hold_cnt <= HOLD_W'(1)) state_nxt = ST_RUN;
            end
        endcase
    end

    assign busy     = (state == ST_LOAD_TIME) || (state == ST_LOAD_ALARM) || (state == ST_STOP);
    assign busy_nxt = (state_nxt == ST_LOAD_TIME) || (state_nxt == ST_LOAD_ALARM) ||
                      (state_nxt == ST_STOP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            field    <= FLD_H1;
            hold_cnt <= '0;
            alaon    <= 1'b0;
        end else begin
            state <= state_nxt;
            field <= field_nxt;
            if (!busy && busy_nxt)
                hold_cnt <= HOLD_W'(LOAD_HOLD_CYCLES);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            if (toggle_alaon) alaon <= ~alaon;
        end
    end

    // Edit registers, last-loaded output registers and the shadow copy of the alarm.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {e_hou1, e_hou0, e_min1, e_min0} <= '0;
            {l_hou1, l_hou0, l_min1, l_min0} <= '0;
            {a_hou1, a_hou0, a_min1, a_min0} <= '0;
        end else begin
            if (ld_cur)
                {e_hou1, e_hou0, e_min1, e_min0} <= {cur_hou1, cur_hou0, cur_min1, cur_min0};
            else if (ld_ala)
                {e_hou1, e_hou0, e_min1, e_min0} <= {a_hou1, a_hou0, a_min1, a_min0};
            else if (do_inc)
                {e_hou1, e_hou0, e_min1, e_min0} <= {n_hou1, n_hou0, n_min1, n_min0};
            if (commit)
                {l_hou1, l_hou0, l_min1, l_min0} <= {e_hou1, e_hou0, e_min1, e_min0};
            if (commit && state == ST_SET_ALARM)
                {a_hou1, a_hou0, a_min1, a_min0} <= {e_hou1, e_hou0, e_min1, e_min0};
        end
    end

`ifdef CLOCK_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_SECONDS + 1);

    logic             alarm_q;
    logic [SNZ_W-1:0] snz_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
            muted   <= 1'b0;
            snz_cnt <= '0;
        end else begin
            alarm_q <= alarm;
            if (snooze_req) begin
                muted   <= 1'b1;
                snz_cnt <= SNZ_W'(SNOOZE_SECONDS);
            end else if ((alarm_q && !alarm) || (state != ST_STOP && state_nxt == ST_STOP)) begin
                muted   <= 1'b0;
                snz_cnt <= '0;
            end else if (tick_1hz && muted) begin
                if (snz_cnt <= SNZ_W'(1)) begin
                    muted   <= 1'b0;
                    snz_cnt <= '0;
                end else begin
                    snz_cnt <= snz_cnt - SNZ_W'(1);
                end
            end
        end
    end
`else
    logic unused_snooze;
    assign unused_snooze = tick_1hz ^ snooze_req;
    assign muted         = 1'b0;
`endif

    assign editing = (state == ST_SET_TIME) || (state == ST_SET_ALARM);
    assign hou1    = editing ? e_hou1 : l_hou1;
    assign hou0    = editing ? e_hou0 : l_hou0;
    assign min1    = editing ? e_min1 : l_min1;
    assign min0    = editing ? e_min0 : l_min0;

    assign loatim     = (state == ST_LOAD_TIME);
    assign loaala     = (state == ST_LOAD_ALARM);
    assign stoala     = (state == ST_STOP);
    assign buzzer     = alarm & ~muted;
    assign edit_field = field;

    always_comb begin
        case (state)
            ST_RUN:       edit_mode = MODE_RUN;
            ST_SET_TIME:  edit_mode = MODE_SET_TIME;
            ST_SET_ALARM: edit_mode = MODE_SET_ALARM;
            default:      edit_mode = MODE_BUSY;
        endcase
    end

endmodule

// File: tb/tb_clock_setup_ctrl.sv
// Self-checking bench for clock_setup_ctrl: directed scenarios plus randomized
// time/alarm edits checked against an arithmetic HH:MM reference model.
module tb_clock_setup_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_1hz, btn_mode, btn_next, btn_inc, alarm;
    logic [1:0] cur_hou1;
    logic [3:0] cur_hou0, cur_min1, cur_min0;
    logic [1:0] hou1;
    logic [3:0] hou0, min1, min0;
    logic       loatim, loaala, stoala, alaon, buzzer;
    logic [1:0] edit_mode, edit_field;

    int n_checks = 0;
    int n_fail   = 0;
    int tim_hh, tim_mm, ala_hh, ala_mm;
    int load_hh, load_mm;

    clock_setup_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_next   (btn_next),
        .btn_inc    (btn_inc),
        .alarm      (alarm),
        .cur_hou1   (cur_hou1),
        .cur_hou0   (cur_hou0),
        .cur_min1   (cur_min1),
        .cur_min0   (cur_min0),
        .hou1       (hou1),
        .hou0       (hou0),
        .min1       (min1),
        .min0       (min0),
        .loatim     (loatim),
        .loaala     (loaala),
        .stoala     (stoala),
        .alaon      (alaon),
        .buzzer     (buzzer),
        .edit_mode  (edit_mode),
        .edit_field (edit_field)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bcd(input int hh, input int mm);
        return 32'(((hh / 10) << 12) | ((hh % 10) << 8) | ((mm / 10) << 4) | (mm % 10));
    endfunction

    function automatic logic [31:0] shown();
        return {18'd0, hou1, hou0, min1, min0};
    endfunction

    // Reference behaviour of one inc press on field fld, as arithmetic on hours/minutes.
    task automatic model_inc(inout int hh, inout int mm, input int fld);
        int t, u;
        case (fld)
            0: begin
                t = (hh / 10 + 1) % 3;
                u = hh % 10;
                if (t == 2 && u > 3) u = 0;
                hh = t * 10 + u;
            end
            1: begin
                t = hh / 10;
                hh = t * 10 + (hh % 10 + 1) % ((t == 2) ? 4 : 10);
            end
            2: mm = ((mm / 10 + 1) % 6) * 10 + mm % 10;
            default: mm = (mm / 10) * 10 + (mm % 10 + 1) % 10;
        endcase
    endtask

    // b = {mode, next, inc}; returns on the falling edge after the capturing edge.
    task automatic press(input logic [2:0] b);
        @(negedge clock);
        {btn_mode, btn_next, btn_inc} = b;
        @(negedge clock);
        {btn_mode, btn_next, btn_inc} = 3'b000;
    endtask

    task automatic tick();
        @(negedge clock);
        tick_1hz = 1'b1;
        @(negedge clock);
        tick_1hz = 1'b0;
    endtask

    task automatic set_cur(input int hh, input int mm);
        cur_hou1 = 2'(hh / 10);
        cur_hou0 = 4'(hh % 10);
        cur_min1 = 4'(mm / 10);
        cur_min0 = 4'(mm % 10);
    endtask

    task automatic hold_check(input string tag, input logic [2:0] strobes,
                              input int hh, input int mm, input int inc_at);
        for (int i = 0; i < 12; i++) begin
            check({tag, "_strobe"}, {29'd0, loatim, loaala, stoala}, {29'd0, strobes});
            check({tag, "_mode"}, {30'd0, edit_mode}, 32'd3);
            check({tag, "_data"}, shown(), bcd(hh, mm));
            btn_inc = (i == inc_at);
            @(negedge clock);
            btn_inc = 1'b0;
        end
        check({tag, "_strobe_end"}, {29'd0, loatim, loaala, stoala}, 32'd0);
        check({tag, "_mode_end"}, {30'd0, edit_mode}, 32'd0);
    endtask

    task automatic edit_random(inout int hh, inout int mm, input string tag);
        int n;
        for (int f = 0; f < 4; f++) begin
            n = $urandom_range(0, 11);
            repeat (n) begin
                press(3'b001);
                model_inc(hh, mm, f);
            end
            check({tag, "_digits"}, shown(), bcd(hh, mm));
            if (f < 3) begin
                press(3'b010);
                check({tag, "_field"}, {30'd0, edit_field}, 32'(f + 1));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        {tick_1hz, btn_mode, btn_next, btn_inc, alarm} = 5'b0;
        set_cur(0, 0);
        ala_hh = 0; ala_mm = 0;
        repeat (3) @(negedge clock);
        check("reset_outputs",
              {9'd0, hou1, hou0, min1, min0, loatim, loaala, stoala, alaon, buzzer,
               edit_mode, edit_field}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Commit the current time 00:00 without edits.
        press(3'b100);
        check("enter_set_time", {30'd0, edit_mode}, 32'd1);
        check("enter_field", {30'd0, edit_field}, 32'd0);
        repeat (3) press(3'b010);
        check("field_m0", {30'd0, edit_field}, 32'd3);
        press(3'b010);
        hold_check("load_time0", 3'b100, 0, 0, -1);

        // Alarm 07:30.
        press(3'b100);
        press(3'b100);
        check("enter_set_alarm", {30'd0, edit_mode}, 32'd2);
        press(3'b010);
        repeat (7) press(3'b001);
        press(3'b010);
        repeat (3) press(3'b001);
        press(3'b010);
        press(3'b010);
        ala_hh = 7; ala_mm = 30;
        hold_check("load_alarm", 3'b010, 7, 30, -1);
        check("run_holds_loaded", shown(), bcd(7, 30));

        press(3'b001);
        check("alaon_toggle", {31'd0, alaon}, 32'd1);

        // Simultaneous mode+inc: only mode acts; then the 20..23 hour rule.
        set_cur(18, 45);
        press(3'b101);
        check("prio_mode", {30'd0, edit_mode}, 32'd1);
        check("prio_alaon", {31'd0, alaon}, 32'd1);
        check("cur_loaded", shown(), bcd(18, 45));
        press(3'b001);
        check("h1_to_2_clears_h0", shown(), bcd(20, 45));
        press(3'b010);
        for (int k = 1; k <= 4; k++) begin
            press(3'b001);
            check("h0_wrap_at_20", {28'd0, hou0}, 32'(k % 4));
        end
        press(3'b100);
        check("abandon_to_alarm", shown(), bcd(7, 30));
        press(3'b100);
        check("abandon_to_run", {30'd0, edit_mode}, 32'd0);
        check("abandon_keeps_loaded", shown(), bcd(7, 30));

        // Alarm rising during edit leaves the state alone.
        press(3'b100);
        alarm = 1'b1;
        repeat (3) @(negedge clock);
        check("alarm_in_set", {30'd0, edit_mode}, 32'd1);
        alarm = 1'b0;
        press(3'b100);
        press(3'b100);

        // Stop strobe with an ignored inc during the hold.
        alarm = 1'b1;
        @(negedge clock);
        check("buzzer_on", {31'd0, buzzer}, 32'd1);
        press(3'b100);
        hold_check("stop", 3'b001, 7, 30, 4);
        check("alaon_after_stop", {31'd0, alaon}, 32'd1);

        // Snooze.
        press(3'b001);
        check("snooze_alaon", {31'd0, alaon}, 32'd1);
`ifdef CLOCK_SNOOZE_EN
        check("snooze_muted", {31'd0, buzzer}, 32'd0);
        repeat (299) tick();
        check("snooze_299", {31'd0, buzzer}, 32'd0);
`else
        check("snooze_ignored", {31'd0, buzzer}, 32'd1);
        repeat (299) tick();
        check("snooze_299", {31'd0, buzzer}, 32'd1);
`endif
        tick();
        check("snooze_300", {31'd0, buzzer}, 32'd1);
        alarm = 1'b0;
        @(negedge clock);
        check("buzzer_off", {31'd0, buzzer}, 32'd0);

        // Randomized time and alarm edits.
        for (int r = 0; r < 5; r++) begin
            tim_hh = $urandom_range(0, 23);
            tim_mm = $urandom_range(0, 59);
            set_cur(tim_hh, tim_mm);
            press(3'b100);
            check("rnd_cur", shown(), bcd(tim_hh, tim_mm));
            edit_random(tim_hh, tim_mm, "rnd_time");
            press(3'b010);
            hold_check("rnd_load_time", 3'b100, tim_hh, tim_mm, -1);
            press(3'b100);
            press(3'b100);
            check("rnd_shadow", shown(), bcd(ala_hh, ala_mm));
            edit_random(ala_hh, ala_mm, "rnd_alarm");
            press(3'b010);
            hold_check("rnd_load_alarm", 3'b010, ala_hh, ala_mm, -1);
        end

        // Asynchronous reset during a load.
        set_cur(12, 34);
        press(3'b100);
        repeat (4) press(3'b010);
        repeat (3) @(negedge clock);
        check("pre_reset_loatim", {31'd0, loatim}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("reset_drops_loatim", {31'd0, loatim}, 32'd0);
        check("reset_mode", {30'd0, edit_mode}, 32'd0);
        check("reset_data", shown(), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("after_reset_alaon", {31'd0, alaon}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_setup_ctrl.md
# clock_setup_ctrl

User-facing controller that sequences the alarm clock datapath, which sits beside it in the clock subsystem. It turns three debounced push-button pulses into:
- BCD digit editing of the time and alarm values;
- held load strobes into the clock (`loatim`, `loaala`);
- alarm enable/stop control, plus an optional snooze.

The clock samples its control inputs only on its internal one-second edge. This block therefore holds every strobe, with stable data, long enough to be captured.

## Interface
Parameters:
- LOAD_HOLD_CYCLES, 12, clock cycles each load/stop strobe is held; must exceed the clock's internal tick period (10 cycles).
- SNOOZE_SECONDS, 300, tick_1hz pulses the buzzer stays muted after a snooze.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick_1hz  in  1  single-cycle pulse once per second
- btn_mode  in  1  single-cycle pulse, debounced
- btn_next  in  1  single-cycle pulse, debounced
- btn_inc  in  1  single-cycle pulse, debounced
- alarm  in  1  alarm output of the clock
- cur_hou1  in  2  current time tens of hours
- cur_hou0  in  4  current time units of hours
- cur_min1  in  4  current time tens of minutes
- cur_min0  in  4  current time units of minutes
- hou1  out  2  load data to clock
- hou0  out  4  load data to clock
- min1  out  4  load data to clock
- min0  out  4  load data to clock
- loatim  out  1  load time strobe
- loaala  out  1  load alarm strobe
- stoala  out  1  stop alarm strobe
- alaon  out  1  alarm enable
- buzzer  out  1  audible alarm
- edit_mode  out  2  0 run, 1 set time, 2 set alarm, 3 busy loading/stopping
- edit_field  out  2  0 H1, 1 H0, 2 M1, 3 M0

## Operation
- Reset value of every output is 0. Data outputs read 00:00, so the clock resets to 00:00. Shadow alarm registers also reset to 00:00.
- States: RUN, SET_TIME, SET_ALARM, LOAD_TIME, LOAD_ALARM, STOP.
- RUN with alarm=0:
  - btn_mode → SET_TIME; edit regs ← cur_* time, field ← H1.
  - btn_inc → toggle alaon.
- RUN with alarm=1:
  - btn_mode → STOP.
  - btn_inc → snooze.
  - btn_next ignored.
- SET_TIME and SET_ALARM:
  - btn_inc increments the current field with wrap: H1 0–2; H0 0–9, or 0–3 when H1=2; M1 0–5; M0 0–9.
  - Incrementing H1 to 2 while H0>3 clears H0 to 0.
  - btn_next advances the field. On M0 it commits: SET_TIME → LOAD_TIME, SET_ALARM → LOAD_ALARM.
  - btn_mode abandons the edit: SET_TIME → SET_ALARM (edit regs ← shadow alarm, field ← H1); SET_ALARM → RUN.
- LOAD_TIME, LOAD_ALARM, STOP each:
  - Assert the respective strobe (loatim / loaala / stoala) for exactly LOAD_HOLD_CYCLES cycles, with hou/min outputs held constant, then → RUN.
  - LOAD_ALARM also copies the edit regs into the shadow alarm registers on entry.
- Buttons pressed while busy (edit_mode=3) are ignored.
- Simultaneous buttons: btn_mode > btn_next > btn_inc; only the highest-priority button acts in a given cycle.
- In RUN, the hou/min outputs keep their last loaded value.
- buzzer = alarm & ~muted.

## Timing
- Button → state/field/digit update: 1 cycle; registered outputs change on the next clock edge.
- Strobe rises the cycle after the commit button and stays high LOAD_HOLD_CYCLES cycles. edit_mode=3 for the same window; it returns to 0 on the cycle the strobe falls.
- Hold counter width is $clog2(LOAD_HOLD_CYCLES+1), counting down to 0.
- Reset asserted mid-load drops every strobe immediately (asynchronous) and returns the block to RUN.
- The alarm rising edge while in SET_* or a load state does not change state. The alarm is serviced once the block is back in RUN.

## Configuration
- CLOCK_SNOOZE_EN defined:
  - btn_inc during alarm sets `muted` and loads a counter with SNOOZE_SECONDS.
  - The counter decrements on tick_1hz; at 0 it clears `muted`.
  - `muted` also clears when alarm falls or when STOP is entered.
- CLOCK_SNOOZE_EN undefined:
  - No snooze counter; muted is tied to 0.
  - btn_inc during alarm is ignored.

## Structure
- Shared package clock_ctrl_pkg holds:
  - the state enum;
  - the field enum;
  - digit limit constants (H1_MAX=2, H0_MAX=9, H0_MAX_AT_20=3, M1_MAX=5, M0_MAX=9);
  - the edit_mode encodings.
- One sub-module, bcd_field_editor: combinational next-value logic for the four digits given field, inc and the limit rules. The FSM, hold counter and snooze counter stay in the top module.

## Test plan
- Reset, then btn_mode, 4× btn_next with no inc → loatim high 12 cycles with data 00:00; edit_mode=3 during the hold; RUN afterwards.
- Set alarm to 07:30 (mode, mode, inc edits, next ×4) → loaala high 12 cycles with hou1=0, hou0=7, min1=3, min0=0.
- In set time, H1=1, H0=8, then inc H1 → H1=2, H0=0; inc H0 four times → 1,2,3,0 (wrap at 3).
- alarm=1 in RUN, btn_mode → stoala high 12 cycles; a btn_inc during the hold does not toggle alaon.
- CLOCK_SNOOZE_EN defined, alarm=1, btn_inc → buzzer 0 for 300 tick_1hz pulses, then 1 while alarm is still 1. Undefined → buzzer stays 1.
- btn_mode and btn_inc in the same cycle in RUN → only SET_TIME is entered; alaon is unchanged.
